// File: rtl/cpu_defs.sv
// Shared CPU definitions: fetch FSM encoding, the NOP word and the default boot address.
package cpu_defs;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and the instruction memory (slave).
interface inst_fetch_if;

  // Handshake: the master raises imem_req with imem_addr and holds both stable until the
  // slave answers with a one-cycle imem_ack carrying imem_rdata; a request is never withdrawn.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues imem requests, buffers a word across a stall, and
// drains an in-flight request after a redirect so its data never reaches IF/ID.
module inst_fetch
  import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pause,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    inst_fetch_if.master        imem,
    output logic [31:0]         pc_o,
    output logic [31:0]         inst_o,
    output logic                valid_o,
    output logic                fetch_stall,
    output fetch_state_t        state_o
);

    fetch_state_t state_q, state_d;
    logic         run_q, run_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  pc_o_q, pc_o_d;
    logic [31:0]  inst_q, inst_d;
    logic         valid_q, valid_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic [31:0]  hold_inst_q, hold_inst_d;

    logic         req_active;
    logic         ack;
    logic [31:0]  target;
    logic [31:0]  pc_inc;

    // run_q keeps imem_req low during reset and lets it rise on the first edge after release.
    assign req_active = run_q && (state_q != HOLD);
    assign ack        = req_active && imem.imem_ack;
    assign target     = {redirect_pc[31:2], 2'b00};
    assign pc_inc     = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        run_d        = 1'b1;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        pc_o_d       = pc_o_q;
        inst_d       = inst_q;
        valid_d      = valid_q;
        hold_pc_d    = hold_pc_q;
        hold_inst_d  = hold_inst_q;

        if (redirect) begin
            pc_d        = target;
            valid_d     = 1'b0;
            inst_d      = NOP;
            hold_pc_d   = 32'h0;
            hold_inst_d = NOP;
            unique case (state_q)
                FETCH: begin
                    if (ack || !req_active) begin
                        state_d = FETCH;
                    end else begin
                        // The old request must complete at its own address before the new pc goes out.
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                DRAIN:   state_d = ack ? FETCH : DRAIN;
                default: state_d = FETCH;
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (ack) begin
                        pc_d = pc_inc;
                        if (pause) begin
                            hold_pc_d   = pc_q;
                            hold_inst_d = imem.imem_rdata;
                            state_d     = HOLD;
                        end else begin
                            pc_o_d  = pc_q;
                            inst_d  = imem.imem_rdata;
                            valid_d = 1'b1;
                        end
                    end else if (req_active && !pause) begin
                        valid_d = 1'b0;
                        inst_d  = NOP;
                    end
                end
                HOLD: begin
                    if (!pause) begin
                        pc_o_d  = hold_pc_q;
                        inst_d  = hold_inst_q;
                        valid_d = 1'b1;
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (ack) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FETCH;
            run_q        <= 1'b0;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'h0;
            pc_o_q       <= 32'h0;
            inst_q       <= NOP;
            valid_q      <= 1'b0;
            hold_pc_q    <= 32'h0;
            hold_inst_q  <= NOP;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            pc_o_q       <= pc_o_d;
            inst_q       <= inst_d;
            valid_q      <= valid_d;
            hold_pc_q    <= hold_pc_d;
            hold_inst_q  <= hold_inst_d;
        end
    end

    assign imem.imem_req  = req_active;
    assign imem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;
    assign fetch_stall    = req_active && !imem.imem_ack;
    assign pc_o           = pc_o_q;
    assign inst_o         = inst_q;
    assign valid_o        = valid_q;
    assign state_o        = state_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the posedge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port pause, input, 1, downstream stall from the hazard unit; while 1, the outputs hold.
REQ-005 SHALL have port redirect, input, 1, a branch or jump taken this cycle.
REQ-006 SHALL have port redirect_pc, input, 32, the target address; bits [1:0] are ignored and treated as 00.
REQ-007 SHALL have port imem_req, output, 1, instruction-memory request.
REQ-008 SHALL have port imem_addr, output, 32, the request address.
REQ-009 SHALL have port imem_ack, input, 1, read data valid this cycle.
REQ-010 SHALL have port imem_rdata, input, 32, the instruction word.
REQ-011 SHALL have ports pc_o and inst_o, output, 32 each, the fetched instruction and its address, feeding the IF/ID register.
REQ-012 SHALL have port valid_o, output, 1, meaning pc_o/inst_o hold a real instruction.
REQ-013 SHALL have port fetch_stall, output, 1, meaning fetch is waiting on memory.

Function
REQ-014 SHALL implement states FETCH, HOLD and DRAIN.
REQ-015 Memory protocol: imem_req SHALL stay high with imem_addr stable until imem_ack, and SHALL never drop with a request outstanding.
REQ-016 FETCH: imem_req=1 and imem_addr=pc.
REQ-017 FETCH with ack, no pause, no redirect: pc_o<=pc, inst_o<=imem_rdata, valid_o<=1, pc<=pc+4; stay in FETCH, issuing back-to-back requests.
REQ-018 FETCH with ack and pause: capture imem_rdata and pc in the hold buffer, pc<=pc+4, go to HOLD; outputs hold.
REQ-019 FETCH with no ack and no pause: valid_o<=0 and inst_o<=0, inserting a NOP bubble.
REQ-020 FETCH with no ack and pause: outputs hold.
REQ-021 fetch_stall SHALL be combinational, equal to (state==FETCH or DRAIN) and !imem_ack.
REQ-022 HOLD: imem_req=0. When pause=0, load outputs from the hold buffer, set valid_o<=1 and go to FETCH.
REQ-023 Redirect SHALL have highest priority in every state: pc<=redirect_pc & ~3, valid_o<=0, inst_o<=0, and the hold buffer is discarded. This applies even while pause=1.
REQ-024 Redirect in FETCH without ack SHALL go to DRAIN; the old request completes and its data is discarded.
REQ-025 Redirect in FETCH with ack SHALL discard the data and go to FETCH at the new pc.
REQ-026 DRAIN: imem_req=1 at the old address; on ack go to FETCH with the new pc.
REQ-027 A second redirect during DRAIN SHALL update pc and remain in DRAIN.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-029 pc_o, inst_o and valid_o SHALL be registered outputs.
REQ-030 Whenever valid_o=0, inst_o SHALL be 0.

Reset
REQ-031 While rst=0: pc=RESET_PC, state=FETCH, imem_req=0, pc_o=0, inst_o=0, valid_o=0, fetch_stall=0, hold buffer cleared.
REQ-032 imem_req SHALL rise on the first posedge after rst deasserts.
REQ-033 Reset mid-request SHALL abandon the request; the memory is reset by the same rst.

Structure
REQ-034 The state encoding, the NOP encoding (32'h0) and the default RESET_PC SHALL live in the shared package cpu_defs.
REQ-035 A single module SHALL be used with no sub-module; the hold buffer is two 32-bit registers.

Verification
REQ-036 Zero-wait streaming: ack every cycle -> pc_o = 0, 4, 8, 12 on consecutive cycles with valid_o=1 and fetch_stall=0.
REQ-037 2-cycle memory latency -> fetch_stall=1 for one cycle per fetch, valid_o alternates 0/1, inst_o=0 in bubble cycles.
REQ-038 pause=1 for 3 cycles with ack arriving in cycle 1 -> HOLD, imem_req=0; on release pc_o=4 and inst_o=captured word, then the fetch of 8 begins.
REQ-039 redirect to 32'h100 while the request to 8 is pending -> DRAIN, the ack for 8 is discarded, the next imem_addr=32'h100, and no instruction from 8 ever appears on valid_o.
REQ-040 redirect_pc=32'h203 -> imem_addr=32'h200; start at pc 32'hFFFF_FFFC -> the next fetch is 0.
REQ-041 rst pulled low while imem_req=1 -> all outputs 0 asynchronously, and after release imem_addr=RESET_PC.
